blink_multi: RTL and testbench

Multi-channel, run-time configurable blink/heartbeat generator. Each of NCH channels runs its own wrap counter with a programmable period and output mode. Each channel emits a registered LED level and a one-cycle wrap flag. It sits beside the status logic and drives board LEDs and heartbeat strobes for downstream monitors. Every channel replaces a fixed-period single blinker.

---
 rtl/blink_pkg.sv | 17 +
 rtl/blink_chan.sv | 61 ++++++
 rtl/blink_multi.sv | 40 ++++
 tb/tb_blink_multi.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types and defaults for the multi-channel blink generator.
// Imported by blink_chan and blink_multi.
package blink_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        TOGGLE = 2'd1,
        PULSE  = 2'd2,
        ON     = 2'd3
    } blink_mode_t;

    // All-ones period, i.e. the slowest wrap for a given counter width
    function automatic logic [31:0] def_period(input int cbits);
        return (32'd1 << cbits) - 32'd1;
    endfunction

endpackage

// File: rtl/blink_chan.sv
// One blink channel: wrap counter, toggle bit and registered led/flg.
// A load clears the phase; outputs on that edge still use the old state.
module blink_chan
    import blink_pkg::*;
#(
    parameter int CBITS = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CBITS-1:0] cfg_period,
    input  blink_mode_t      cfg_mode,
    output logic             led,
    output logic             flg
);

    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] period;
    blink_mode_t      mode;
    logic             tog;
    logic             w;
    logic             led_nxt;

    assign w = (cnt == '0);

    always_comb begin
        led_nxt = 1'b0;
        unique case (mode)
            OFF:    led_nxt = 1'b0;
            TOGGLE: led_nxt = tog;
            PULSE:  led_nxt = w;
            ON:     led_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            period <= CBITS'(def_period(CBITS));
            mode   <= TOGGLE;
            tog    <= 1'b0;
            led    <= 1'b0;
            flg    <= 1'b0;
        end else begin
            flg <= en & w;
            if (en)
                led <= led_nxt;
            if (load) begin
                period <= cfg_period;
                mode   <= cfg_mode;
                cnt    <= '0;
                tog    <= 1'b0;
            end else if (en) begin
                cnt <= (cnt == period) ? '0 : cnt + CBITS'(1);
                tog <= tog ^ w;
            end
        end
    end

endmodule

// File: rtl/blink_multi.sv
// Multi-channel configurable blink/heartbeat generator.
// Out-of-range channel writes match no channel and are dropped.
module blink_multi
    import blink_pkg::*;
#(
    parameter int CBITS = 11,
    parameter int NCH   = 4,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [CBITS-1:0] cfg_period,
    input  logic [1:0]       cfg_mode,
    output logic [NCH-1:0]   led,
    output logic [NCH-1:0]   flg
);

    logic [NCH-1:0] load;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign load[i] = cfg_we && (cfg_ch == CHW'(i));

        blink_chan #(
            .CBITS(CBITS)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .load      (load[i]),
            .cfg_period(cfg_period),
            .cfg_mode  (blink_mode_t'(cfg_mode)),
            .led       (led[i]),
            .flg       (flg[i])
        );
    end

endmodule

// File: tb/tb_blink_multi.sv
// Scoreboard bench for blink_multi (CBITS=4, NCH=3).
// Stimulus queues per-edge expectations; a monitor pops and compares.
module tb_blink_multi;

    localparam int CBITS = 4;
    localparam int NCH   = 3;
    localparam int CHW   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CHW-1:0]   cfg_ch = '0;
    logic [CBITS-1:0] cfg_period = '0;
    logic [1:0]       cfg_mode = '0;
    logic [NCH-1:0]   led;
    logic [NCH-1:0]   flg;

    typedef struct {
        int             tag;
        logic [NCH-1:0] led;
        logic [NCH-1:0] flg;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    blink_multi #(
        .CBITS(CBITS),
        .NCH  (NCH),
        .CHW  (CHW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_period(cfg_period),
        .cfg_mode  (cfg_mode),
        .led       (led),
        .flg       (flg)
    );

    // Default period 15, n = count of enabled edges since reset
    function automatic bit dflg(input int n);
        return (n >= 1) && (((n - 1) % 16) == 0);
    endfunction

    function automatic bit dled(input int n);
        return (n >= 2) && (((n - 2) % 32) < 16);
    endfunction

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mx = sb.pop_front();
            tests++;
            if (led !== mx.led || flg !== mx.flg) begin
                fails++;
                $display("FAIL edge tag %0d: led=%b flg=%b, expected led=%b flg=%b",
                         mx.tag, led, flg, mx.led, mx.flg);
            end
        end
    end

    task automatic drive(input logic r, input logic e, input logic we,
                         input logic [CHW-1:0] ch, input logic [CBITS-1:0] p,
                         input logic [1:0] m, input logic [NCH-1:0] el,
                         input logic [NCH-1:0] ef, input int tag);
        exp_t x;
        @(negedge clk);
        rst        = r;
        en         = e;
        cfg_we     = we;
        cfg_ch     = ch;
        cfg_period = p;
        cfg_mode   = m;
        x.tag = tag;
        x.led = el;
        x.flg = ef;
        sb.push_back(x);
        @(posedge clk);
    endtask

    task automatic do_reset(input int scn);
        for (int k = 0; k < 2; k++)
            drive(1'b1, 1'b1, 1'b0, '0, '0, 2'd0, '0, '0, scn * 1000 + k);
    endtask

    task automatic run_scn(input int scn, input int nedge);
        int n;
        n = 0;
        for (int e = 1; e <= nedge; e++) begin
            logic             r, ev, we;
            logic [CHW-1:0]   ch;
            logic [CBITS-1:0] p;
            logic [1:0]       m;
            logic [NCH-1:0]   el, ef;
            r = 1'b0; ev = 1'b1; we = 1'b0;
            ch = '0; p = '0; m = 2'd0;
            case (scn)
                2: if (e == 10) begin we = 1'b1; ch = 2'd1; p = 4'd2; m = 2'd2; end
                3: ev = !(e >= 5 && e <= 9);
                4: if (e == 7) begin we = 1'b1; ch = 2'd3; p = 4'd0; m = 2'd1; end
                5: if (e == 10) begin we = 1'b1; ch = 2'd2; p = 4'd0; m = 2'd1; end
                6: if (e == 20) begin r = 1'b1; we = 1'b1; ch = 2'd0; p = 4'd2; m = 2'd3; end
                default: ;
            endcase
            if (r)
                n = 0;
            else if (ev)
                n++;
            for (int c = 0; c < NCH; c++) begin
                el[c] = r ? 1'b0 : dled(n);
                ef[c] = (r || !ev) ? 1'b0 : dflg(n);
            end
            if (scn == 2 && e >= 11) begin
                el[1] = ((e - 11) % 3) == 0;
                ef[1] = ((e - 11) % 3) == 0;
            end
            if (scn == 5 && e >= 11) begin
                el[2] = ((e - 11) % 2) == 1;
                ef[2] = 1'b1;
            end
            drive(r, ev, we, ch, p, m, el, ef, scn * 1000 + e);
        end
    endtask

    initial begin
        do_reset(1);
        run_scn(1, 40);
        do_reset(2);
        run_scn(2, 30);
        do_reset(3);
        run_scn(3, 40);
        do_reset(4);
        run_scn(4, 40);
        do_reset(5);
        run_scn(5, 20);
        do_reset(6);
        run_scn(6, 45);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
